wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back end of the MEM/WB pipeline interface: consumes the MEM/WB register outputs,
//  selects ALU or memory result, commits it to the 32-entry GPR file, and serves the two
//  ID-stage read ports with same-cycle write-through bypass. Also exports the selected
//  WB value/address for the EX forwarding unit and keeps a committed-write counter.
// PARAMETERS
//  DATA_W   32  datapath / register width
//  ADDR_W   5   register address width (2**ADDR_W entries)
//  CNT_W    16  width of committed-write counter
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       synchronous reset, active low
//  Control_in     in   2       from MEM/WB: [1]=RegWrite, [0]=MemtoReg
//  ALU_in         in   DATA_W  from MEM/WB ALU result
//  Mem_in         in   DATA_W  from MEM/WB load data
//  Rt_Rd_Addr_in  in   ADDR_W  from MEM/WB destination register
//  Rs_Addr        in   ADDR_W  ID read port A address
//  Rt_Addr        in   ADDR_W  ID read port B address
//  Rs_Data        out  DATA_W  read port A data (combinational)
//  Rt_Data        out  DATA_W  read port B data (combinational)
//  WB_Data        out  DATA_W  selected write-back value (to forwarding unit)
//  WB_Addr        out  ADDR_W  = Rt_Rd_Addr_in
//  WB_En          out  1       effective write enable (RegWrite && addr!=0 && rst_n)
//  Wr_Count       out  CNT_W   number of committed writes since reset (registered)
// BEHAVIOUR
//  - WB_Data = MemtoReg ? Mem_in : ALU_in; purely combinational, zero latency.
//  - WB_En = rst_n & Control_in[1] & (Rt_Rd_Addr_in != 0).
//  - Commit: on posedge clk with WB_En=1, regs[Rt_Rd_Addr_in] <= WB_Data; visible in the
//    array from the next cycle. Writes to r0 are discarded; r0 always reads 0.
//  - Reads: Rs_Data/Rt_Data combinational. If addr==0 -> 0. Else if WB_En && addr==WB_Addr
//    -> WB_Data (write-through bypass, same cycle). Else regs[addr].
//  - Both read ports may hit the bypass simultaneously; both return WB_Data.
//  - Reset: posedge clk with rst_n=0 clears all regs to 0 and Wr_Count to 0; any write
//    presented that cycle is dropped. While rst_n=0: Rs_Data=Rt_Data=0, WB_En=0;
//    WB_Data/WB_Addr still follow inputs (don't-care to consumers).
//  - Reset mid-stream: in-flight MEM/WB contents are not committed; first commit occurs on
//    the first posedge with rst_n=1 and WB_En=1.
//  - Wr_Count increments by 1 on each posedge with WB_En=1; wraps 2**CNT_W-1 -> 0
//    silently. r0-targeted and RegWrite=0 cycles do not count.
//  - Control_in=2'b01 (MemtoReg without RegWrite): no commit, no count, no bypass.
//  - No X propagation: all regs defined after first reset cycle; bench must reset first.
// TESTING
//  1 Reset: rst_n=0 one cycle with Control_in=2'b10,Addr=5,ALU_in=0xDEAD -> r5 stays 0,
//    Wr_Count=0, Rs_Data=0 during reset.
//  2 ALU write: Control=2'b10,Addr=8,ALU_in=0x12345678 -> next cycle Rs_Addr=8 reads
//    0x12345678; Wr_Count=1.
//  3 Load write + bypass: Control=2'b11,Addr=9,Mem_in=0xCAFEF00D, Rs_Addr=Rt_Addr=9 same
//    cycle -> both ports 0xCAFEF00D before the edge; WB_En=1.
//  4 r0 guard: Control=2'b11,Addr=0,Mem_in=0xFFFFFFFF -> WB_En=0, Rs_Addr=0 reads 0,
//    Wr_Count unchanged.
//  5 No-write: Control=2'b01,Addr=8,Mem_in=0x1 -> r8 keeps 0x12345678, no bypass.
//  6 Counter wrap (CNT_W=4): 17 back-to-back valid writes to r1..r31 -> Wr_Count=1;
//    random read/write mix vs. reference model, 10k cycles, zero mismatches.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage register file: picks the ALU or load result, commits it to the GPRs,
// serves two combinational read ports with same-cycle bypass, and counts committed writes.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        Control_in,
  input  logic [DATA_W-1:0] ALU_in,
  input  logic [DATA_W-1:0] Mem_in,
  input  logic [ADDR_W-1:0] Rt_Rd_Addr_in,
  input  logic [ADDR_W-1:0] Rs_Addr,
  input  logic [ADDR_W-1:0] Rt_Addr,
  output logic [DATA_W-1:0] Rs_Data,
  output logic [DATA_W-1:0] Rt_Data,
  output logic [DATA_W-1:0] WB_Data,
  output logic [ADDR_W-1:0] WB_Addr,
  output logic              WB_En,
  output logic [CNT_W-1:0]  Wr_Count
);

  localparam int unsigned       NumRegs = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);

  logic              reg_write;
  logic              mem_to_reg;
  logic              wb_en;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [DATA_W-1:0] rs_data, rt_data;

  assign reg_write  = Control_in[1];
  assign mem_to_reg = Control_in[0];

  always_comb begin
    wb_data = mem_to_reg ? Mem_in : ALU_in;
  end

  // Reset gates the enable so nothing in flight commits or bypasses during reset.
  always_comb begin
    wb_en = rst_n & reg_write & (Rt_Rd_Addr_in != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en) begin
      regs_q[Rt_Rd_Addr_in] <= wb_data;
    end
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (wb_en) begin
      wr_count_d = wr_count_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  // Priority: r0 and reset force zero, then the in-flight write, then stored contents.
  always_comb begin
    rs_data = regs_q[Rs_Addr];
    if (!rst_n || (Rs_Addr == '0)) begin
      rs_data = '0;
    end else if (wb_en && (Rs_Addr == Rt_Rd_Addr_in)) begin
      rs_data = wb_data;
    end
  end

  always_comb begin
    rt_data = regs_q[Rt_Addr];
    if (!rst_n || (Rt_Addr == '0)) begin
      rt_data = '0;
    end else if (wb_en && (Rt_Addr == Rt_Rd_Addr_in)) begin
      rt_data = wb_data;
    end
  end

  assign Rs_Data  = rs_data;
  assign Rt_Data  = rt_data;
  assign WB_Data  = wb_data;
  assign WB_Addr  = Rt_Rd_Addr_in;
  assign WB_En    = wb_en;
  assign Wr_Count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed table, reset/wrap sequences, and a randomized run
// against an array-based reference model. Counter width is 4 to exercise wrap.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic [1:0]  Control_in;
  logic [31:0] ALU_in, Mem_in;
  logic [4:0]  Rt_Rd_Addr_in, Rs_Addr, Rt_Addr;
  logic [31:0] Rs_Data, Rt_Data, WB_Data;
  logic [4:0]  WB_Addr;
  logic        WB_En;
  logic [3:0]  Wr_Count;

  wb_regfile #(
    .DATA_W(32),
    .ADDR_W(5),
    .CNT_W (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Control_in   (Control_in),
    .ALU_in       (ALU_in),
    .Mem_in       (Mem_in),
    .Rt_Rd_Addr_in(Rt_Rd_Addr_in),
    .Rs_Addr      (Rs_Addr),
    .Rt_Addr      (Rt_Addr),
    .Rs_Data      (Rs_Data),
    .Rt_Data      (Rt_Data),
    .WB_Data      (WB_Data),
    .WB_Addr      (WB_Addr),
    .WB_En        (WB_En),
    .Wr_Count     (Wr_Count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] m_regs [32];
  int          m_cnt;

  typedef struct {
    logic [1:0]  ctrl;
    logic [4:0]  waddr;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic [31:0] exp_wbd;
    logic        exp_en;
    int          exp_cnt;  // counter value after the edge
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] c, input logic [4:0] wa,
                       input logic [31:0] a, input logic [31:0] m,
                       input logic [4:0] ra, input logic [4:0] rb);
    rst_n = r; Control_in = c; Rt_Rd_Addr_in = wa; ALU_in = a; Mem_in = m;
    Rs_Addr = ra; Rt_Addr = rb;
  endtask

  function automatic logic [31:0] model_read(input logic r, input logic [1:0] c,
                                             input logic [4:0] wa, input logic [31:0] wbd,
                                             input logic [4:0] a);
    if (!r || a == 5'd0) return 32'h0;
    if (c[1] && wa != 5'd0 && a == wa) return wbd;
    return m_regs[a];
  endfunction

  task automatic model_edge(input logic r, input logic [1:0] c, input logic [4:0] wa,
                            input logic [31:0] wbd);
    if (!r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 0;
    end else if (c[1] && wa != 5'd0) begin
      m_regs[wa] = wbd;
      m_cnt = (m_cnt + 1) % 16;
    end
  endtask

  initial begin
    vecs[0] = '{2'b10, 5'd8, 32'h12345678, 32'h0, 5'd8, 5'd0,
                32'h12345678, 32'h0, 32'h12345678, 1'b1, 1};
    vecs[1] = '{2'b00, 5'd0, 32'h0, 32'h0, 5'd8, 5'd5,
                32'h12345678, 32'h0, 32'h0, 1'b0, 1};
    vecs[2] = '{2'b11, 5'd9, 32'h0, 32'hCAFEF00D, 5'd9, 5'd9,
                32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 2};
    vecs[3] = '{2'b11, 5'd0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd9,
                32'h0, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0, 2};
    vecs[4] = '{2'b01, 5'd8, 32'h0, 32'h1, 5'd8, 5'd8,
                32'h12345678, 32'h12345678, 32'h1, 1'b0, 2};
    vecs[5] = '{2'b00, 5'd3, 32'h77, 32'h0, 5'd8, 5'd9,
                32'h12345678, 32'hCAFEF00D, 32'h77, 1'b0, 2};

    // Reset with a write presented: must be dropped, reads forced to zero.
    drive(1'b0, 2'b10, 5'd5, 32'hDEAD, 32'h0, 5'd5, 5'd5);
    @(negedge clk);
    chk("rst_rs", Rs_Data, 32'h0);
    chk("rst_rt", Rt_Data, 32'h0);
    chk("rst_en", 32'(WB_En), 32'h0);
    chk("rst_wbd", WB_Data, 32'hDEAD);
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);
    @(negedge clk);
    chk("rst_r5", Rs_Data, 32'h0);
    chk("rst_cnt", 32'(Wr_Count), 32'h0);
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].ctrl, vecs[i].waddr, vecs[i].alu, vecs[i].mem,
            vecs[i].rs, vecs[i].rt);
      @(negedge clk);
      chk($sformatf("v%0d_rs", i), Rs_Data, vecs[i].exp_rs);
      chk($sformatf("v%0d_rt", i), Rt_Data, vecs[i].exp_rt);
      chk($sformatf("v%0d_wbd", i), WB_Data, vecs[i].exp_wbd);
      chk($sformatf("v%0d_en", i), 32'(WB_En), 32'(vecs[i].exp_en));
      chk($sformatf("v%0d_wba", i), 32'(WB_Addr), 32'(vecs[i].waddr));
      @(posedge clk); #1;
      chk($sformatf("v%0d_cnt", i), 32'(Wr_Count), 32'(vecs[i].exp_cnt));
    end

    // Mid-stream reset: in-flight write to r3 is not committed, counter clears.
    drive(1'b0, 2'b10, 5'd3, 32'hAAAA, 32'h0, 5'd8, 5'd3);
    @(negedge clk);
    chk("mrst_rs", Rs_Data, 32'h0);
    chk("mrst_en", 32'(WB_En), 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 5'd0, 32'h0, 32'h0, 5'd8, 5'd3);
    @(negedge clk);
    chk("mrst_r8", Rs_Data, 32'h0);
    chk("mrst_r3", Rt_Data, 32'h0);
    chk("mrst_cnt", 32'(Wr_Count), 32'h0);
    @(posedge clk); #1;

    // 17 back-to-back writes wrap the 4-bit counter to 1.
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 2'b10, 5'(i), 32'(i * 32'h111), 32'h0, 5'd0, 5'd0);
      @(posedge clk); #1;
    end
    drive(1'b1, 2'b00, 5'd0, 32'h0, 32'h0, 5'd17, 5'd1);
    @(negedge clk);
    chk("wrap_cnt", 32'(Wr_Count), 32'h1);
    chk("wrap_r17", Rs_Data, 32'(17 * 32'h111));
    chk("wrap_r1", Rt_Data, 32'h111);
    @(posedge clk); #1;

    for (int i = 0; i < 32; i++) m_regs[i] = (i >= 1 && i <= 17) ? 32'(i * 32'h111) : 32'h0;
    m_cnt = 1;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 10000; c++) begin
      logic        r;
      logic [1:0]  ct;
      logic [4:0]  wa, ra, rb;
      logic [31:0] a, m, wbd;
      r  = ($urandom_range(0, 63) != 0);
      ct = 2'($urandom);
      wa = 5'($urandom);
      a  = $urandom;
      m  = $urandom;
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      wbd = ct[0] ? m : a;
      drive(r, ct, wa, a, m, ra, rb);
      @(negedge clk);
      chk("rnd_rs", Rs_Data, model_read(r, ct, wa, wbd, ra));
      chk("rnd_rt", Rt_Data, model_read(r, ct, wa, wbd, rb));
      chk("rnd_wbd", WB_Data, wbd);
      chk("rnd_en", 32'(WB_En), 32'(r && ct[1] && wa != 5'd0));
      chk("rnd_cnt", 32'(Wr_Count), 32'(m_cnt));
      model_edge(r, ct, wa, wbd);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
